// File: rtl/vga_timing_ctrl_if.sv
// Raster timing bundle: run enable in, sync/video/coordinate/marker outputs back.
// The master modport belongs to the timing generator, the slave to its consumers.
interface vga_timing_ctrl_if #(
  parameter int CW = 10
);
  logic          EN;
  logic          PIX_TICK;
  logic          HSYNC;
  logic          VSYNC;
  logic          VIDEO_ON;
  logic [CW-1:0] PIX_X;
  logic [CW-1:0] PIX_Y;
  logic          LINE_START;
  logic          FRAME_START;

  modport master (
    input  EN,
    output PIX_TICK, HSYNC, VSYNC, VIDEO_ON, PIX_X, PIX_Y, LINE_START, FRAME_START
  );

  modport slave (
    output EN,
    input  PIX_TICK, HSYNC, VSYNC, VIDEO_ON, PIX_X, PIX_Y, LINE_START, FRAME_START
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing on the system clock: a divide-by-DIV pixel strobe steps the
// horizontal/vertical counters; every output is a flop fed from the post-step counts.
module vga_timing_ctrl #(
  parameter int DIV      = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CW       = 10
) (
  input  logic              CLKIN,
  input  logic              ACLR,
  vga_timing_ctrl_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          SYNC_ON  = (SYNC_POL != 0);

  logic [DW-1:0] div_reg, div_next;
  logic [CW-1:0] hcnt_reg, hcnt_next;
  logic [CW-1:0] vcnt_reg, vcnt_next;
  logic          step, h_wrap, v_wrap;
  logic          hs_win, vs_win, video_next;

  logic          pix_tick_reg, line_start_reg, frame_start_reg;
  logic          hsync_reg, vsync_reg, video_on_reg;
  logic [CW-1:0] pix_x_reg, pix_y_reg;

  always_comb begin
    step      = bus.EN && (div_reg == DIV_LAST);
    h_wrap    = (hcnt_reg == H_LAST);
    v_wrap    = (vcnt_reg == V_LAST);
    div_next  = div_reg;
    hcnt_next = hcnt_reg;
    vcnt_next = vcnt_reg;
    if (bus.EN) begin
      div_next = step ? '0 : div_reg + DW'(1);
    end
    if (step) begin
      hcnt_next = h_wrap ? '0 : hcnt_reg + CW'(1);
      if (h_wrap) begin
        vcnt_next = v_wrap ? '0 : vcnt_reg + CW'(1);
      end
    end
  end

  // Windows are judged on the counts the step is about to load, so outputs align with PIX_X/PIX_Y.
  always_comb begin
    hs_win     = (hcnt_next >= HS_BEG) && (hcnt_next <= HS_END);
    vs_win     = (vcnt_next >= VS_BEG) && (vcnt_next <= VS_END);
    video_next = (hcnt_next < H_ACT) && (vcnt_next < V_ACT);
  end

  always_ff @(posedge CLKIN or posedge ACLR) begin
    if (ACLR) begin
      div_reg         <= '0;
      hcnt_reg        <= '0;
      vcnt_reg        <= '0;
      pix_tick_reg    <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      hsync_reg       <= ~SYNC_ON;
      vsync_reg       <= ~SYNC_ON;
      video_on_reg    <= 1'b0;
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
    end else begin
      div_reg         <= div_next;
      hcnt_reg        <= hcnt_next;
      vcnt_reg        <= vcnt_next;
      pix_tick_reg    <= step;
      line_start_reg  <= step && h_wrap;
      frame_start_reg <= step && h_wrap && v_wrap;
      // Level outputs only move on a step, so the reset state survives until the first pixel.
      if (step) begin
        hsync_reg    <= hs_win ? SYNC_ON : ~SYNC_ON;
        vsync_reg    <= vs_win ? SYNC_ON : ~SYNC_ON;
        video_on_reg <= video_next;
        pix_x_reg    <= hcnt_next;
        pix_y_reg    <= vcnt_next;
      end
    end
  end

  assign bus.PIX_TICK    = pix_tick_reg;
  assign bus.LINE_START  = line_start_reg;
  assign bus.FRAME_START = frame_start_reg;
  assign bus.HSYNC       = hsync_reg;
  assign bus.VSYNC       = vsync_reg;
  assign bus.VIDEO_ON    = video_on_reg;
  assign bus.PIX_X       = pix_x_reg;
  assign bus.PIX_Y       = pix_y_reg;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Two small raster instances (DIV=3 active-low sync, DIV=2 active-high sync) compared every
// cycle against a position model derived from the count of enabled clock edges since release.
module tb_vga_timing_ctrl;

  typedef struct packed {
    logic       tick;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ls;
    logic       fs;
    logic [3:0] x;
    logic [3:0] y;
  } out_t;

  localparam out_t RST_A = '{tick: 1'b0, hs: 1'b1, vs: 1'b1, von: 1'b0, ls: 1'b0, fs: 1'b0, x: 4'd0, y: 4'd0};
  localparam out_t RST_B = '{tick: 1'b0, hs: 1'b0, vs: 1'b0, von: 1'b0, ls: 1'b0, fs: 1'b0, x: 4'd0, y: 4'd0};

  logic clk;
  logic aclr;
  int   e_cnt;
  bit   last_en;
  int   passed;
  int   total;

  vga_timing_ctrl_if #(.CW(4)) ifa ();
  vga_timing_ctrl_if #(.CW(4)) ifb ();

  vga_timing_ctrl #(
    .DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0), .CW(4)
  ) dut_a (.CLKIN(clk), .ACLR(aclr), .bus(ifa));

  vga_timing_ctrl #(
    .DIV(2), .H_ACTIVE(5), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1), .CW(4)
  ) dut_b (.CLKIN(clk), .ACLR(aclr), .bus(ifb));

  assign ifb.EN = ifa.EN;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position = number of completed pixel steps, folded into (x, y) over the whole frame.
  function automatic out_t model(input int dv, input int ha, input int hf, input int hw, input int hb,
                                 input int va, input int vf, input int vw, input int vb, input bit pol);
    out_t o;
    int   ht, vt, k, p, h, v;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    k  = e_cnt / dv;
    o  = '{tick: 1'b0, hs: ~pol, vs: ~pol, von: 1'b0, ls: 1'b0, fs: 1'b0, x: 4'd0, y: 4'd0};
    if (k > 0) begin
      p      = k % (ht * vt);
      h      = p % ht;
      v      = p / ht;
      o.tick = last_en && (e_cnt % dv == 0);
      o.ls   = o.tick && (h == 0);
      o.fs   = o.tick && (p == 0);
      o.hs   = (h >= ha + hf && h < ha + hf + hw) ? pol : ~pol;
      o.vs   = (v >= va + vf && v < va + vf + vw) ? pol : ~pol;
      o.von  = (h < ha) && (v < va);
      o.x    = 4'(h);
      o.y    = 4'(v);
    end
    return o;
  endfunction

  function automatic out_t exp_a();
    return model(3, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0);
  endfunction

  function automatic out_t exp_b();
    return model(2, 5, 1, 1, 1, 1, 1, 1, 1, 1'b1);
  endfunction

  function automatic out_t got_a();
    return out_t'({ifa.PIX_TICK, ifa.HSYNC, ifa.VSYNC, ifa.VIDEO_ON,
                   ifa.LINE_START, ifa.FRAME_START, ifa.PIX_X, ifa.PIX_Y});
  endfunction

  function automatic out_t got_b();
    return out_t'({ifb.PIX_TICK, ifb.HSYNC, ifb.VSYNC, ifb.VIDEO_ON,
                   ifb.LINE_START, ifb.FRAME_START, ifb.PIX_X, ifb.PIX_Y});
  endfunction

  // Called at posedge+1: drive EN, take one edge, sample at the next posedge+1.
  task automatic cycle(input bit en_v);
    ifa.EN = en_v;
    @(posedge clk);
    #1;
    if (aclr) begin
      e_cnt   = 0;
      last_en = 1'b0;
    end else begin
      if (en_v) e_cnt++;
      last_en = en_v;
    end
  endtask

  task automatic assert_async_reset();
    #1;
    aclr = 1'b1;
    #1;
    e_cnt   = 0;
    last_en = 1'b0;
  endtask

  task automatic release_reset();
    #4;
    aclr = 1'b0;
  endtask

  task automatic test_reset();
    aclr   = 1'b1;
    ifa.EN = 1'b1;
    repeat (3) cycle(1'b1);
    total++;
    if (got_a() !== RST_A) $display("FAIL reset_a got=%h exp=%h", got_a(), RST_A);
    else passed++;
    total++;
    if (got_b() !== RST_B) $display("FAIL reset_b got=%h exp=%h", got_b(), RST_B);
    else passed++;
    $display("test_reset done");
  endtask

  task automatic test_first_ticks();
    int first_a, first_b;
    first_a = -1;
    first_b = -1;
    release_reset();
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b1);
      if (ifa.PIX_TICK && first_a < 0) first_a = i;
      if (ifb.PIX_TICK && first_b < 0) first_b = i;
      total++;
      if (got_a() !== exp_a()) $display("FAIL first_a cyc=%0d got=%h exp=%h", i, got_a(), exp_a());
      else passed++;
      total++;
      if (got_b() !== exp_b()) $display("FAIL first_b cyc=%0d got=%h exp=%h", i, got_b(), exp_b());
      else passed++;
    end
    total++;
    if (first_a !== 3) $display("FAIL first_tick_a got=%0d exp=3", first_a);
    else passed++;
    total++;
    if (first_b !== 2) $display("FAIL first_tick_b got=%0d exp=2", first_b);
    else passed++;
    $display("test_first_ticks done");
  endtask

  task automatic test_frames();
    int fs_n, ls_n, hs_n, vs_n;
    fs_n = 0; ls_n = 0; hs_n = 0; vs_n = 0;
    // 720 cycles = 240 steps of dut_a = exactly two 120-pixel frames.
    for (int i = 0; i < 720; i++) begin
      cycle(1'b1);
      fs_n += int'(ifa.FRAME_START);
      ls_n += int'(ifa.LINE_START);
      hs_n += int'(ifa.PIX_TICK && !ifa.HSYNC);
      vs_n += int'(ifa.PIX_TICK && !ifa.VSYNC);
      total++;
      if (got_a() !== exp_a()) $display("FAIL frame_a cyc=%0d got=%h exp=%h", i, got_a(), exp_a());
      else passed++;
      total++;
      if (got_b() !== exp_b()) $display("FAIL frame_b cyc=%0d got=%h exp=%h", i, got_b(), exp_b());
      else passed++;
    end
    total++;
    if (fs_n !== 2) $display("FAIL frame_count got=%0d exp=2", fs_n);
    else passed++;
    total++;
    if (ls_n !== 16) $display("FAIL line_count got=%0d exp=16", ls_n);
    else passed++;
    total++;
    if (hs_n !== 48) $display("FAIL hsync_ticks got=%0d exp=48", hs_n);
    else passed++;
    total++;
    if (vs_n !== 60) $display("FAIL vsync_ticks got=%0d exp=60", vs_n);
    else passed++;
    $display("test_frames done");
  endtask

  task automatic test_enable_gap();
    bit   found;
    int   n;
    out_t held;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      cycle(1'b1);
      found = ifa.PIX_TICK && (ifa.PIX_X == 4'd5);
    end
    total++;
    if (!found) $display("FAIL gap_wait got=timeout exp=PIX_X5");
    else passed++;
    cycle(1'b1);
    held = got_a();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0);
      total++;
      if (got_a() !== held) $display("FAIL gap_freeze_a cyc=%0d got=%h exp=%h", i, got_a(), held);
      else passed++;
      total++;
      if (got_b() !== exp_b()) $display("FAIL gap_b cyc=%0d got=%h exp=%h", i, got_b(), exp_b());
      else passed++;
    end
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b1);
      n++;
      found = ifa.PIX_TICK;
    end
    total++;
    if (n !== 2 || ifa.PIX_X !== 4'd6) $display("FAIL gap_resume got=n%0d/x%0d exp=n2/x6", n, ifa.PIX_X);
    else passed++;
    total++;
    if (got_a() !== exp_a()) $display("FAIL gap_resume_a got=%h exp=%h", got_a(), exp_a());
    else passed++;
    $display("test_enable_gap done");
  endtask

  task automatic test_async_reset();
    bit found;
    int fs_n;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      cycle(1'b1);
      found = (ifa.PIX_Y == 4'd3) && (ifa.PIX_X == 4'd4);
    end
    total++;
    if (!found) $display("FAIL areset_wait got=timeout exp=PIX_Y3");
    else passed++;
    assert_async_reset();
    total++;
    if (got_a() !== RST_A) $display("FAIL areset_a got=%h exp=%h", got_a(), RST_A);
    else passed++;
    total++;
    if (got_b() !== RST_B) $display("FAIL areset_b got=%h exp=%h", got_b(), RST_B);
    else passed++;
    cycle(1'b1);
    release_reset();
    fs_n = 0;
    for (int i = 0; i < 359; i++) begin
      cycle(1'b1);
      fs_n += int'(ifa.FRAME_START);
      total++;
      if (got_a() !== exp_a()) $display("FAIL restart_a cyc=%0d got=%h exp=%h", i, got_a(), exp_a());
      else passed++;
    end
    total++;
    if (fs_n !== 0) $display("FAIL spurious_frame got=%0d exp=0", fs_n);
    else passed++;
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        assert_async_reset();
        total++;
        if (got_a() !== RST_A || got_b() !== RST_B)
          $display("FAIL rand_reset got=%h/%h exp=%h/%h", got_a(), got_b(), RST_A, RST_B);
        else passed++;
        cycle(1'($urandom_range(0, 1)));
        release_reset();
      end
      cycle($urandom_range(0, 9) < 7);
      total++;
      if (got_a() !== exp_a()) $display("FAIL rand_a cyc=%0d got=%h exp=%h", i, got_a(), exp_a());
      else passed++;
      total++;
      if (got_b() !== exp_b()) $display("FAIL rand_b cyc=%0d got=%h exp=%h", i, got_b(), exp_b());
      else passed++;
    end
    $display("test_random done");
  endtask

  initial begin
    aclr    = 1'b1;
    ifa.EN  = 1'b0;
    e_cnt   = 0;
    last_en = 1'b0;
    passed  = 0;
    total   = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_first_ticks();
    test_frames();
    test_enable_gap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Sequences the 25 MHz pixel rate for the VGA output path. It runs on the 100 MHz system clock and uses an internal divide-by-DIV pixel strobe, so no derived clock is used. It drives the horizontal and vertical raster counters and produces HSYNC, VSYNC, the active-video window, pixel coordinates and frame/line markers. These outputs feed the pixel/colour generator and the VGA pins.

Parameters:
DIV, 4, CLKIN cycles per pixel; legal range 2..16.
H_ACTIVE, 640, visible pixels per line.
H_FP, 16, horizontal front porch in pixels.
H_SYNC, 96, horizontal sync width in pixels.
H_BP, 48, horizontal back porch in pixels.
V_ACTIVE, 480, visible lines per frame.
V_FP, 10, vertical front porch in lines.
V_SYNC, 2, vertical sync width in lines.
V_BP, 33, vertical back porch in lines.
SYNC_POL, 0, sync assertion level; 0 means active-low.
CW, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
CLKIN  in  1  system clock, 100 MHz.
ACLR  in  1  asynchronous reset, active-high.
EN  in  1  run enable; low freezes all timing.
PIX_TICK  out  1  one-cycle strobe marking the first CLKIN cycle of each new pixel.
HSYNC  out  1  horizontal sync.
VSYNC  out  1  vertical sync.
VIDEO_ON  out  1  high inside the active window.
PIX_X  out  CW  current horizontal count (hcnt).
PIX_Y  out  CW  current vertical count (vcnt).
LINE_START  out  1  one-cycle pulse when hcnt wraps to 0.
FRAME_START  out  1  one-cycle pulse when (hcnt, vcnt) wraps to (0, 0).

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (default 800); V_TOTAL = sum of the four V parameters (default 525).
- Divider: div counts 0..DIV-1 while EN=1.
  - Internal step strobe s = EN && (div == DIV-1).
  - On s, div returns to 0.
- Counters: on s, hcnt increments; at H_TOTAL-1 it wraps to 0.
  - vcnt increments only on the hcnt wrap; at V_TOTAL-1 it wraps to 0.
  - All counter arithmetic is unsigned, width CW.
- Registered outputs: every output is a flop. Each is updated from the post-step counter values on the same edge that steps the counters, so all outputs change together.
  - PIX_TICK <= s.
  - LINE_START <= s && hcnt == H_TOTAL-1.
  - FRAME_START <= s && hcnt == H_TOTAL-1 && vcnt == V_TOTAL-1.
  - HSYNC = SYNC_POL while next hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (defaults 656..751); otherwise ~SYNC_POL.
  - VSYNC = SYNC_POL while next vcnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (defaults 490..491); otherwise ~SYNC_POL.
  - VIDEO_ON = (next hcnt < H_ACTIVE) && (next vcnt < V_ACTIVE).
  - PIX_X and PIX_Y equal the raw counters; they are meaningful only while VIDEO_ON=1.
- Latency: the first step occurs on the DIV-th rising edge after ACLR deasserts with EN=1. Outputs hold constant for DIV cycles per pixel.
- Reset (ACLR=1, asynchronous, any time, including mid-line or mid-frame):
  - div=0, hcnt=0, vcnt=0.
  - PIX_TICK=0, LINE_START=0, FRAME_START=0.
  - VIDEO_ON=0, PIX_X=0, PIX_Y=0.
  - HSYNC=VSYNC=~SYNC_POL.
  - After release, timing restarts at (0,0). No FRAME_START or LINE_START pulse for that initial position.
  - VIDEO_ON rises at the first step; pixel (0,0) is skipped for the first frame only.
- EN=0: div, counters and all level outputs hold. Pulse outputs are 0. On re-enable, div resumes from its held value.
- Simultaneous events:
  - ACLR overrides EN and s.
  - The hcnt wrap and vcnt wrap on the same step produce both LINE_START and FRAME_START in the same cycle.

Test Plan:
1. ACLR 1→0 with EN=1 → first PIX_TICK is high during cycle 4 after release. PIX_TICK period is 4 CLKIN. PIX_X reads 1, 2, 3 on successive ticks. LINE_START and FRAME_START stay 0.
2. Run one full line → HSYNC is 0 for exactly 96 ticks (384 CLKIN), starting at PIX_X=656. VIDEO_ON is high for PIX_X 0..639 in lines 0..479. LINE_START period is 3200 CLKIN.
3. Run two full frames → VSYNC is 0 only at PIX_Y 490..491 (1600 ticks). FRAME_START period is 420000 ticks (1,680,000 CLKIN). FRAME_START coincides with LINE_START.
4. Drop EN for 10 cycles at PIX_X=100 → no PIX_TICK, and all outputs are frozen. After re-enable, the next tick shows PIX_X=101, with the remaining div phase preserved.
5. Assert ACLR asynchronously (mid-cycle) at PIX_Y=300 → all outputs go to their reset values immediately. After release, timing restarts from (0,0) with no spurious FRAME_START.
6. Override DIV=2, H_TOTAL/V_TOTAL small (e.g. 8/4 pixel/lines with 1-wide porches and sync) → PIX_TICK every 2 CLKIN. HSYNC, VSYNC and VIDEO_ON windows match the parameter formulas exactly.
